// File: rtl/eth_frame_rx.sv
// RMII receive framer: finds preamble+SFD, packs dibits LSB-first into bytes for the packet
// buffer RAM, and reports length/FCS/alignment status once per frame at end of carrier.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  S_HUNT | counting 2'b01 preamble dibits, waiting for a qualified SFD
//  S_DATA | packing bytes, writing RAM, running CRC until done_in
module eth_frame_rx #(
    parameter int RAM_SIZE            = 2048,
    parameter int MAX_FRAME_LEN       = 1522,
    parameter int MIN_FRAME_LEN       = 64,
    parameter int PREAMBLE_MIN_DIBITS = 8,
    localparam int AW                 = $clog2(RAM_SIZE)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          inclk,
    input  logic [1:0]    in,
    input  logic          done_in,
    input  logic [AW-1:0] base_addr,
    output logic          write_req,
    output logic [AW-1:0] write_addr,
    output logic [7:0]    write_val,
    output logic          busy,
    output logic          frame_done,
    output logic [10:0]   frame_len,
    output logic          frame_ok,
    output logic [2:0]    err
);

    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic {S_HUNT, S_DATA} state_t;

    state_t        state, state_nx;
    logic          rst_meta, rst_sync_n;
    logic [3:0]    pre_cnt;
    logic [AW-1:0] base_lat;
    logic [10:0]   byte_cnt, cnt_nx;
    logic [1:0]    dibit_idx, idx_nx;
    logic [7:0]    shreg, byte_full;
    logic [31:0]   crc, crc_nx;
    logic          len_flag, len_flag_nx;
    logic          sfd_hit, byte_done, byte_keep;

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta   <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_sync_n <= rst_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) state <= S_HUNT;
        else             state <= state_nx;
    end

    // Next-byte values include a byte completed in the done_in cycle itself.
    always_comb begin
        state_nx    = state;
        sfd_hit     = (state == S_HUNT) && inclk && (in == 2'b11) &&
                      (pre_cnt >= 4'(PREAMBLE_MIN_DIBITS));
        byte_done   = (state == S_DATA) && inclk && (dibit_idx == 2'd3);
        byte_full   = {in, shreg[7:2]};
        byte_keep   = byte_done && (byte_cnt < 11'(MAX_FRAME_LEN));
        crc_nx      = byte_done ? crc_upd(crc, byte_full) : crc;
        cnt_nx      = byte_keep ? byte_cnt + 11'd1 : byte_cnt;
        len_flag_nx = len_flag | (byte_done & ~byte_keep);
        idx_nx      = inclk ? dibit_idx + 2'd1 : dibit_idx;
        case (state)
            S_HUNT: if (sfd_hit) state_nx = S_DATA;
            S_DATA: if (done_in) state_nx = S_HUNT;
            default: state_nx = S_HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            pre_cnt    <= '0;
            base_lat   <= '0;
            byte_cnt   <= '0;
            dibit_idx  <= '0;
            shreg      <= '0;
            crc        <= '1;
            len_flag   <= 1'b0;
            write_req  <= 1'b0;
            write_addr <= '0;
            write_val  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_len  <= '0;
            frame_ok   <= 1'b0;
            err        <= '0;
        end else begin
            write_req  <= 1'b0;
            frame_done <= 1'b0;
            if (state == S_HUNT) begin
                if (sfd_hit) begin
                    base_lat  <= base_addr;
                    byte_cnt  <= '0;
                    dibit_idx <= '0;
                    crc       <= '1;
                    len_flag  <= 1'b0;
                    busy      <= 1'b1;
                    pre_cnt   <= '0;
                end else if (done_in) begin
                    pre_cnt <= '0;
                end else if (inclk) begin
                    if (in == 2'b01) pre_cnt <= (pre_cnt == 4'hF) ? pre_cnt : pre_cnt + 4'd1;
                    else             pre_cnt <= '0;
                end
            end else begin
                if (inclk) begin
                    shreg     <= byte_full;
                    dibit_idx <= idx_nx;
                end
                if (byte_keep) begin
                    write_req  <= 1'b1;
                    write_addr <= base_lat + AW'(byte_cnt);
                    write_val  <= byte_full;
                end
                byte_cnt <= cnt_nx;
                crc      <= crc_nx;
                len_flag <= len_flag_nx;
                if (done_in) begin
                    frame_done <= 1'b1;
                    frame_len  <= cnt_nx;
                    err        <= {idx_nx != 2'd0,
                                   len_flag_nx | (cnt_nx < 11'(MIN_FRAME_LEN)),
                                   crc_nx != CRC_RESIDUE};
                    frame_ok   <= (idx_nx == 2'd0) && !len_flag_nx &&
                                  (cnt_nx >= 11'(MIN_FRAME_LEN)) && (crc_nx == CRC_RESIDUE);
                    busy       <= 1'b0;
                    pre_cnt    <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_eth_frame_rx.sv
// Randomized bench for eth_frame_rx: frames are built with a real FCS, the expected RAM
// writes and per-frame results are queued up front and a negedge monitor checks them.
module tb_eth_frame_rx;

    localparam int RAM_SIZE = 2048;
    localparam int AW       = 11;
    localparam int MAXL     = 1522;
    localparam int MINL     = 64;
    localparam int PRE_MIN  = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          inclk = 1'b0;
    logic [1:0]    din = 2'b00;
    logic          done_in = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          write_req;
    logic [AW-1:0] write_addr;
    logic [7:0]    write_val;
    logic          busy;
    logic          frame_done;
    logic [10:0]   frame_len;
    logic          frame_ok;
    logic [2:0]    err;

    eth_frame_rx #(.RAM_SIZE(RAM_SIZE), .MAX_FRAME_LEN(MAXL), .MIN_FRAME_LEN(MINL),
                   .PREAMBLE_MIN_DIBITS(PRE_MIN)) dut (
        .clk(clk), .reset_n(reset_n), .inclk(inclk), .in(din), .done_in(done_in),
        .base_addr(base_addr), .write_req(write_req), .write_addr(write_addr),
        .write_val(write_val), .busy(busy), .frame_done(frame_done),
        .frame_len(frame_len), .frame_ok(frame_ok), .err(err));

    always #10 clk = ~clk;

    typedef struct { logic [AW-1:0] addr; logic [7:0] val; } wr_t;
    typedef struct { logic [10:0] len; logic [2:0] err; logic ok; logic wr_at_done; } res_t;

    wr_t        wr_q[$];
    res_t       res_q[$];
    logic [7:0] fb[$];
    int         n_vec = 0;
    int         n_err = 0;
    wr_t        mon_w;
    res_t       mon_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (write_req === 1'b1) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 32'(write_addr), 32'hFFFF_FFFF);
                end else begin
                    mon_w = wr_q.pop_front();
                    check("wr_addr", 32'(write_addr), 32'(mon_w.addr));
                    check("wr_val", 32'(write_val), 32'(mon_w.val));
                end
            end
            if (frame_done === 1'b1) begin
                if (res_q.size() == 0) begin
                    check("unexpected_frame_done", 32'(frame_len), 32'hFFFF_FFFF);
                end else begin
                    mon_r = res_q.pop_front();
                    check("frame_len", 32'(frame_len), 32'(mon_r.len));
                    check("err", 32'(err), 32'(mon_r.err));
                    check("frame_ok", 32'(frame_ok), 32'(mon_r.ok));
                    check("wr_with_done", 32'(write_req), 32'(mon_r.wr_at_done));
                end
            end
        end
    end

    // Standard Ethernet CRC-32 (final value, already complemented) of fb[0 .. cnt-1].
    function automatic logic [31:0] crc32_of(input int cnt);
        logic [31:0] c = 32'hFFFF_FFFF;
        for (int i = 0; i < cnt; i++) begin
            c ^= 32'(fb[i]);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic make_frame(input int plen, input bit zero);
        logic [31:0] c;
        fb.delete();
        for (int i = 0; i < plen; i++) fb.push_back(zero ? 8'h00 : 8'($urandom));
        c = zero ? 32'h0 : crc32_of(plen);
        for (int k = 0; k < 4; k++) fb.push_back(c[8*k +: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            inclk   = 1'b0;
            done_in = 1'b0;
        end
    endtask

    task automatic dibit(input logic [1:0] d);
        @(negedge clk);
        inclk   = 1'b1;
        din     = d;
        done_in = 1'b0;
    endtask

    task automatic run_frame(input int pre, input logic [AW-1:0] base, input int extra,
                             input bit coinc, input bit flip);
        int         n;
        int         stored;
        int         last;
        logic [1:0] dib[$];
        logic [31:0] fcs;
        res_t       r;
        n = fb.size();
        if (flip && n > 4) begin
            int idx = $urandom_range(0, n - 5);
            fb[idx] ^= 8'(1 << $urandom_range(0, 7));
        end
        if (pre >= PRE_MIN) begin
            stored = (n < MAXL) ? n : MAXL;
            for (int i = 0; i < stored; i++)
                wr_q.push_back('{AW'((int'(base) + i) % RAM_SIZE), fb[i]});
            if (n >= 4) begin
                fcs = {fb[n-1], fb[n-2], fb[n-3], fb[n-4]};
                r.err[0] = (crc32_of(n - 4) != fcs);
            end else begin
                r.err[0] = 1'b1;
            end
            r.err[1]     = (n < MINL) || (n > MAXL);
            r.err[2]     = (extra % 4) != 0;
            r.len        = 11'(stored);
            r.ok         = (r.err == 3'b000);
            r.wr_at_done = coinc && (extra == 0) && (n > 0) && (n <= MAXL);
            res_q.push_back(r);
        end
        for (int i = 0; i < pre; i++) dib.push_back(2'b01);
        dib.push_back(2'b11);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 4; k++) dib.push_back(2'((fb[i] >> (2 * k)) & 8'h3));
        for (int i = 0; i < extra; i++) dib.push_back(2'($urandom));
        base_addr = base;
        last = (coinc && dib.size() > pre + 1) ? dib.size() - 1 : dib.size();
        for (int i = 0; i < last; i++) begin
            dibit(dib[i]);
            if (i == pre) begin
                @(negedge clk);
                inclk = 1'b0;
                check("busy_after_sfd", 32'(busy), (pre >= PRE_MIN) ? 32'd1 : 32'd0);
            end else if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end
        end
        if (last != dib.size()) begin
            @(negedge clk);
            inclk   = 1'b1;
            din     = dib[last];
            done_in = 1'b1;
        end else begin
            idle($urandom_range(1, 3));
            @(negedge clk);
            done_in = 1'b1;
        end
        idle(4);
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic reset_mid_frame();
        int k = 10;
        make_frame(60, 0);
        for (int i = 0; i < k; i++) wr_q.push_back('{AW'(11'h050 + i), fb[i]});
        base_addr = 11'h050;
        repeat (PRE_MIN) dibit(2'b01);
        dibit(2'b11);
        for (int i = 0; i < k; i++)
            for (int b = 0; b < 4; b++) dibit(2'((fb[i] >> (2 * b)) & 8'h3));
        dibit(2'b10);
        dibit(2'b01);
        idle(3);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_write_req", 32'(write_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_len", 32'(frame_len), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_frame_ok", 32'(frame_ok), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(3);
        repeat (40) dibit(2'b00);
        idle(1);
        @(negedge clk);
        done_in = 1'b1;
        idle(5);
        check("busy_after_reset", 32'(busy), 32'd0);
    endtask

    initial begin
        #(20 * 200000);
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        check("init_write_req", 32'(write_req), 32'd0);
        check("init_busy", 32'(busy), 32'd0);
        check("init_frame_done", 32'(frame_done), 32'd0);
        check("init_frame_len", 32'(frame_len), 32'd0);
        check("init_frame_ok", 32'(frame_ok), 32'd0);
        check("init_err", 32'(err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(4);

        make_frame(60, 0);
        run_frame(8, 11'h100, 0, 0, 0);
        run_frame(8, 11'h100, 0, 0, 1);

        make_frame(60, 1);
        run_frame(6, 11'h200, 0, 0, 0);
        make_frame(60, 0);
        run_frame(8, 11'h200, 0, 0, 0);

        make_frame(1526, 0);
        run_frame(8, 11'h000, 0, 0, 0);
        make_frame(60, 0);
        run_frame(9, AW'(RAM_SIZE - 2), 0, 0, 0);

        make_frame(60, 0);
        run_frame(8, 11'h040, 2, 0, 0);
        run_frame(10, 11'h080, 0, 1, 0);

        fb.delete();
        run_frame(8, 11'h010, 0, 0, 0);
        make_frame(16, 0);
        run_frame(12, 11'h020, 0, 0, 0);

        reset_mid_frame();
        make_frame(60, 0);
        run_frame(8, 11'h300, 0, 0, 0);

        repeat (8) begin
            make_frame($urandom_range(40, 120), 0);
            run_frame($urandom_range(8, 20), AW'($urandom), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        idle(20);
        check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        check("res_queue_drained", 32'(res_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
